// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port into a valid/ready burst stream via a 3-entry buffer.
// Define FIFO_READER_COUNT_EN to add the 32-bit delivered-word counter output word_count_o.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  read_clk_i,
  input  logic                  read_reset_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_read_data_i,
  output logic                  fifo_read_en_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [31:0]           word_count_o
`endif
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic                  pend_q, pend_d;
  logic                  drop_q, drop_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [DATA_WIDTH-1:0] mem_q [3];
  logic                  capture;
  logic                  xfer;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are gated on registered occupancy plus the word in flight, never on out_ready_i.
  assign fifo_read_en_o = !read_reset_i && !flush_i && !fifo_empty_i &&
                          ((3'(occ_q) + 3'(pend_q)) <= 3'd2);

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign out_last_o  = out_valid_o && (burst_q == BURST_MAX);

  // A word landing on the flush edge is the in-flight word, so the flush itself discards it.
  assign capture = pend_q && !drop_q && !flush_i;
  assign xfer    = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    burst_d  = burst_q;
    pend_d   = fifo_read_en_o;
    drop_d   = flush_i && pend_q;
    if (flush_i) begin
      occ_d    = 2'd0;
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      burst_d  = '0;
    end else begin
      occ_d = occ_q + {1'b0, capture} - {1'b0, xfer};
      if (capture) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (xfer) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
        burst_d  = (burst_q == BURST_MAX) ? '0 : burst_q + BW'(1);
      end
    end
  end

  always_ff @(posedge read_clk_i or posedge read_reset_i) begin
    if (read_reset_i) begin
      occ_q    <= 2'd0;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      pend_q   <= 1'b0;
      drop_q   <= 1'b0;
      burst_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      burst_q  <= burst_d;
      if (capture) begin
        mem_q[wr_ptr_q] <= fifo_read_data_i;
      end
    end
  end

`ifdef FIFO_READER_COUNT_EN
  logic [31:0] count_q;

  // Only reset clears the counter; flush leaves the running total alone.
  always_ff @(posedge read_clk_i or posedge read_reset_i) begin
    if (read_reset_i) begin
      count_q <= 32'd0;
    end else if (xfer) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign word_count_o = count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed scoreboard bench with a behavioural FIFO read-port model.
// Covers streaming, backpressure, flush, async reset, BURST_LEN=1 and optional word counter.
module tb_fifo_stream_reader;

  localparam int BLEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        readReset = 1'b1;
  logic        flush     = 1'b0;
  logic        outReady  = 1'b0;
  logic        fifoEmpty;
  logic [7:0]  fifoReadData = 8'd0;
  logic        fifoReadEn;
  logic        outValid;
  logic [7:0]  outData;
  logic        outLast;

  logic        fifoEmpty1;
  logic [15:0] fifoReadData1 = 16'd0;
  logic        fifoReadEn1;
  logic        outValid1;
  logic        outReady1 = 1'b1;
  logic [15:0] outData1;
  logic        outLast1;

`ifdef FIFO_READER_COUNT_EN
  logic [31:0] wordCount;
  logic [31:0] wordCount1;
`endif

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(BLEN)) dut (
    .read_clk_i       (clk),
    .read_reset_i     (readReset),
    .flush_i          (flush),
    .fifo_empty_i     (fifoEmpty),
    .fifo_read_data_i (fifoReadData),
    .fifo_read_en_o   (fifoReadEn),
    .out_valid_o      (outValid),
    .out_ready_i      (outReady),
    .out_data_o       (outData),
    .out_last_o       (outLast)
`ifdef FIFO_READER_COUNT_EN
    ,
    .word_count_o     (wordCount)
`endif
  );

  fifo_stream_reader #(.DATA_WIDTH(16), .BURST_LEN(1)) dut1 (
    .read_clk_i       (clk),
    .read_reset_i     (readReset),
    .flush_i          (flush),
    .fifo_empty_i     (fifoEmpty1),
    .fifo_read_data_i (fifoReadData1),
    .fifo_read_en_o   (fifoReadEn1),
    .out_valid_o      (outValid1),
    .out_ready_i      (outReady1),
    .out_data_o       (outData1),
    .out_last_o       (outLast1)
`ifdef FIFO_READER_COUNT_EN
    ,
    .word_count_o     (wordCount1)
`endif
  );

  // FIFO read-port models: data registered one cycle after an accepted read.
  logic [7:0]  fifoMem [0:127];
  int          wrPtr = 0;
  int          rdPtr = 0;
  logic [15:0] fifoMem1 [0:7];
  int          wrPtr1 = 0;
  int          rdPtr1 = 0;

  assign fifoEmpty  = (wrPtr == rdPtr);
  assign fifoEmpty1 = (wrPtr1 == rdPtr1);

  always @(posedge clk) begin
    if (readReset) begin
      rdPtr <= wrPtr;
    end else if (fifoReadEn && !fifoEmpty) begin
      fifoReadData <= fifoMem[rdPtr];
      rdPtr        <= rdPtr + 1;
    end
  end

  always @(posedge clk) begin
    if (readReset) begin
      rdPtr1 <= wrPtr1;
    end else if (fifoReadEn1 && !fifoEmpty1) begin
      fifoReadData1 <= fifoMem1[rdPtr1];
      rdPtr1        <= rdPtr1 + 1;
    end
  end

  // Scoreboard state and bookkeeping.
  logic [7:0]  expQ  [$];
  logic [15:0] expQ1 [$];
  int          mBurst = 0;
  int          errors = 0;
  int          checks = 0;
  int          cycleNum = 0;
  int          xferCount = 0;
  int          firstXfer = 0;
  int          lastXfer = 0;
  int          startRd = 0;
  int          count1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [7:0] d);
    fifoMem[wrPtr] = d;
    wrPtr = wrPtr + 1;
    expQ.push_back(d);
  endtask

  task automatic clearStats();
    xferCount = 0;
    firstXfer = 0;
    lastXfer  = 0;
  endtask

  // Per-cycle check: read gating, then either the upcoming transfer or the held head word.
  task automatic checkOutput();
    logic [7:0] expData;
    check("rdEnWhileEmpty", {31'd0, fifoReadEn && fifoEmpty}, 32'd0);
    if (!readReset && !flush && outValid && outReady) begin
      check("sbHasWord", {31'd0, expQ.size() > 0}, 32'd1);
      if (expQ.size() > 0) begin
        expData = expQ.pop_front();
        check("xferData", {24'd0, outData}, {24'd0, expData});
        check("xferLast", {31'd0, outLast}, {31'd0, mBurst == BLEN - 1});
        mBurst = (mBurst + 1) % BLEN;
        if (xferCount == 0) firstXfer = cycleNum;
        lastXfer = cycleNum;
        xferCount++;
      end
    end else if (!readReset && outValid && !outReady && expQ.size() > 0) begin
      check("holdData", {24'd0, outData}, {24'd0, expQ[0]});
      check("holdLast", {31'd0, outLast}, {31'd0, mBurst == BLEN - 1});
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic fl);
    @(negedge clk);
    outReady = rdy;
    flush    = fl;
    cycleNum++;
    checkOutput();
  endtask

  initial begin
    #1;
    check("rstValid", {31'd0, outValid}, 32'd0);
    check("rstData", {24'd0, outData}, 32'd0);
    check("rstLast", {31'd0, outLast}, 32'd0);
    check("rstRdEn", {31'd0, fifoReadEn}, 32'd0);
    check("rstValid1", {31'd0, outValid1}, 32'd0);
    @(negedge clk);
    readReset = 1'b0;

    // Steady stream of 0x01..0x08 with out_ready held high.
    applyStimulus(1'b1, 1'b0);
    clearStats();
    for (int i = 1; i <= 8; i++) pushWord(8'(i));
    applyStimulus(1'b1, 1'b0);
    check("latValidLow", {31'd0, outValid}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    check("latValidHigh", {31'd0, outValid}, 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    check("streamCount", 32'(xferCount), 32'd8);
    check("streamSpan", 32'(lastXfer - firstXfer), 32'd7);
    check("streamDrained", 32'(expQ.size()), 32'd0);

    // Backpressure: 6 words queued with out_ready low.
    applyStimulus(1'b0, 1'b0);
    clearStats();
    startRd = rdPtr;
    for (int i = 0; i < 6; i++) pushWord(8'h11 + 8'(i));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    check("bpReads", 32'(rdPtr - startRd), 32'd3);
    check("bpValid", {31'd0, outValid}, 32'd1);
    check("bpHeadData", {24'd0, outData}, 32'h11);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0);
    check("bpCount", 32'(xferCount), 32'd6);
    check("bpSpan", 32'(lastXfer - firstXfer), 32'd5);
    check("bpDrained", 32'(expQ.size()), 32'd0);

    // Flush while a read is in flight and two words are buffered.
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pushWord(8'h21 + 8'(i));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    expQ.delete();
    mBurst = 0;
    applyStimulus(1'b0, 1'b0);
    check("flushValid", {31'd0, outValid}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    check("flushNoLeak", {31'd0, outValid}, 32'd0);
    clearStats();
    for (int i = 0; i < 4; i++) pushWord(8'h31 + 8'(i));
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
    check("postFlushCount", 32'(xferCount), 32'd4);
    check("postFlushDrained", 32'(expQ.size()), 32'd0);

    // Asynchronous reset after two of four words.
    applyStimulus(1'b1, 1'b0);
    clearStats();
    for (int i = 0; i < 4; i++) pushWord(8'h41 + 8'(i));
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    check("preResetXfers", 32'(xferCount), 32'd2);
    @(posedge clk);
    #2;
    readReset = 1'b1;
    #1;
    check("arstValid", {31'd0, outValid}, 32'd0);
    check("arstData", {24'd0, outData}, 32'd0);
    check("arstLast", {31'd0, outLast}, 32'd0);
    check("arstRdEn", {31'd0, fifoReadEn}, 32'd0);
    expQ.delete();
    mBurst = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    readReset = 1'b0;
    clearStats();
    for (int i = 0; i < 4; i++) pushWord(8'h51 + 8'(i));
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
    check("postResetCount", 32'(xferCount), 32'd4);
    check("postResetDrained", 32'(expQ.size()), 32'd0);

    // BURST_LEN=1, DATA_WIDTH=16 instance.
    fifoMem1[wrPtr1] = 16'hA5A5;
    wrPtr1 = wrPtr1 + 1;
    expQ1.push_back(16'hA5A5);
    fifoMem1[wrPtr1] = 16'h5A5A;
    wrPtr1 = wrPtr1 + 1;
    expQ1.push_back(16'h5A5A);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (outValid1 && outReady1) begin
        check("b1HasWord", {31'd0, expQ1.size() > 0}, 32'd1);
        if (expQ1.size() > 0) begin
          check("b1Data", {16'd0, outData1}, {16'd0, expQ1.pop_front()});
          check("b1Last", {31'd0, outLast1}, 32'd1);
          count1++;
        end
      end
    end
    check("b1Count", 32'(count1), 32'd2);

`ifdef FIFO_READER_COUNT_EN
    // Delivered-word counter: survives flush, cleared by reset.
    @(negedge clk);
    readReset = 1'b1;
    #1;
    check("wcReset", wordCount, 32'd0);
    @(negedge clk);
    readReset = 1'b0;
    expQ.delete();
    mBurst = 0;
    for (int i = 0; i < 10; i++) pushWord(8'h60 + 8'(i));
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    mBurst = 0;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pushWord(8'h70 + 8'(i));
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    check("wcTotal", wordCount, 32'd13);
    @(negedge clk);
    readReset = 1'b1;
    #1;
    check("wcCleared", wordCount, 32'd0);
    @(negedge clk);
    readReset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's dual-clock FIFO. It runs entirely in the FIFO's read clock domain and issues `fifo_read_en` against the FIFO's `empty` flag. It captures the FIFO's registered read data, which arrives one cycle after an accepted read, and presents it downstream as a valid/ready stream with burst framing (`out_last`). A 3-entry credit-tracked buffer sustains one word per cycle without any combinational path from `out_ready` to `fifo_read_en`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width; must match the FIFO's data width.
- `BURST_LEN`, default 4: words per burst; `out_last` marks the final word. Legal range is ≥1.

Ports:
- `read_clk`  in  1  block clock; same clock as the FIFO read side.
- `read_reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous discard of buffered and in-flight data.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_data`  in  DATA_WIDTH  FIFO registered read data.
- `fifo_read_en`  out  1  read request to the FIFO.
- `out_valid`  out  1  stream word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  DATA_WIDTH  stream word.
- `out_last`  out  1  final word of the current burst.
- `word_count`  out  32  delivered-word count; present only when `FIFO_READER_COUNT_EN` is defined.

## Operation
- FIFO contract: a read is accepted at a `read_clk` edge where `fifo_read_en` is high and `fifo_empty` is low. `fifo_read_data` then holds the word from the following cycle onward.
- State registers:
  - `occ`: buffer occupancy, 0..3.
  - `pend`: 1 while an accepted read's data has not yet been captured.
  - `burst_cnt`: position within the burst, 0..BURST_LEN-1.
  - `drop`: discard marker used by flush.
- Read issue: `fifo_read_en = !read_reset && !flush && !fifo_empty && (occ + pend <= 2)`. This uses registered state only.
- Capture: the cycle after an accepted read, `fifo_read_data` is written at the buffer tail and `pend` clears. If `drop` is set, the word is discarded instead.
- Simultaneous capture and pop in one cycle leaves `occ` unchanged.
- Output: `out_valid = (occ != 0)`; `out_data` is the head entry; `out_last = out_valid && (burst_cnt == BURST_LEN-1)`.
- Handshake: a transfer occurs when `out_valid && out_ready`. On a transfer, the head pops and `burst_cnt` increments, wrapping to 0 after the last word.
- While `out_valid && !out_ready`, `out_data` and `out_last` are held stable.
- Once `out_valid` rises, it stays high until a transfer occurs.
- Ordering: words are delivered in FIFO order with no loss or duplication, except on flush or reset.
- Flush, for one cycle:
  - `occ` and `burst_cnt` are set to 0 and no read is issued.
  - If `pend` is set, `drop` is set so the arriving word is discarded; `drop` clears on that capture.
  - A handshake in the flush cycle is ignored.
- `BURST_LEN=1`: `out_last` is high on every valid word.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `fifo_read_en`=0. Internally `occ`=0, `pend`=0, `burst_cnt`=0, `drop`=0. `word_count`=0 when compiled in.
- Reset takes effect immediately (asynchronous). On release, the first read may issue in the first cycle with `fifo_empty` low.
- Latency:
  - Read accepted at edge N → data captured at edge N+1 → `out_valid` high in the cycle after edge N+1.
  - From `fifo_empty` falling in cycle C (buffer idle) to `out_valid` is 2 cycles.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and `out_ready` is held high.
- Backpressure:
  - With `out_ready` low, at most 3 words are buffered and no further read issues.
  - When `out_ready` rises, 3 words are delivered back-to-back; the next read issues one cycle later.
- Reset during operation: buffered and in-flight words are lost, because the FIFO pointer has already advanced. The system must reset the FIFO read side together with this block.

## Configuration
- `FIFO_READER_COUNT_EN` defined:
  - Adds the `word_count` output: a 32-bit register incremented on every transfer.
  - Wraps modulo 2^32.
  - Cleared by reset only; flush does not clear it.
- Not defined: no `word_count` port and no counter logic. All other behaviour is identical.

## Test plan
- Steady stream: preload the FIFO with 0x01..0x08, hold `out_ready`=1 → `out_data` 0x01..0x08 on 8 consecutive cycles, `out_last` on 0x04 and 0x08, `fifo_read_en` never high while `fifo_empty`=1.
- Backpressure: load 6 words with `out_ready`=0 → exactly 3 reads accepted, `out_valid`=1, `out_data`=first word held stable. Then set `out_ready`=1 → all 6 words delivered in order, no gaps after the first.
- Flush with read in flight: assert `flush` the cycle after an accepted read while `occ`=2 → `out_valid`=0 next cycle, the in-flight word is never output. The next word read is delivered with `burst_cnt`=0 (`out_last` only on its 4th word).
- Async reset mid-burst: assert `read_reset` between edges after 2 of 4 words → all outputs 0 immediately. After release with reloaded data, `out_last` lands on the 4th word.
- `BURST_LEN=1`, `DATA_WIDTH=16`: stream 0xA5A5, 0x5A5A → `out_last`=1 on both words.
- With `FIFO_READER_COUNT_EN`: transfer 10 words, flush, transfer 3 words → `word_count`=13. After reset → 0.
